// File: rtl/lsu_datapath.sv
// Load/store unit: takes one request at a time, issues one or two aligned memory
// accesses with byte enables, and returns sign/zero-extended load data.
module lsu_datapath #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_address,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_byte_enable,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int BW = 2 * NB;
  localparam int DW = 2 * XLEN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC1  = 3'd1,
    S_ACC2  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  function automatic logic legal_f3(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b011:                 ok = (XLEN == 64);
      3'b100, 3'b101:         ok = !store;
      3'b110:                 ok = !store && (XLEN == 64);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t            state_r, state_nx_s;
  logic              cap_store_r, cap_unsigned_r, cap_cross_r;
  logic [1:0]        cap_size_r;
  logic [OB-1:0]     cap_off_r;
  logic [XLEN-1:0]   cap_base_r;
  logic [NB-1:0]     cap_be_hi_r;
  logic [XLEN-1:0]   cap_wd_hi_r;
  logic [DW-1:0]     rbuf_r, rbuf_s, shifted_s;

  logic              req_ready_r, rsp_valid_r, rsp_fault_r, mem_read_r, mem_write_r;
  logic [XLEN-1:0]   rsp_rdata_r, mem_address_r, mem_wdata_r;
  logic [NB-1:0]     mem_be_r;

  logic              accept_s, req_legal_s, req_cross_s, sgn_s;
  logic [OB-1:0]     req_off_s;
  logic [3:0]        req_nbytes_s;
  logic [4:0]        req_end_s;
  logic [BW-1:0]     req_be_s;
  logic [DW-1:0]     req_wd_s;
  logic [6:0]        nbits_s;
  logic [XLEN-1:0]   lowmask_s, msb_s, load_val_s;

  // Request decode: size, crossing, lane masks and lane-positioned data.
  always_comb begin
    accept_s     = req_valid & req_ready_r;
    req_legal_s  = legal_f3(req_store, req_funct3);
    req_off_s    = req_addr[OB-1:0];
    req_nbytes_s = 4'd1 << req_funct3[1:0];
    req_end_s    = 5'(req_off_s) + {1'b0, req_nbytes_s};
    req_cross_s  = req_end_s > 5'(NB);
    req_be_s     = ((BW'(1) << req_nbytes_s) - BW'(1)) << req_off_s;
    req_wd_s     = DW'(req_wdata) << {req_off_s, 3'b000};
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_FAULT: begin
        if (accept_s) begin
          if (!req_legal_s || (req_cross_s && !ALLOW_MISALIGNED)) begin
            state_nx_s = S_FAULT;
          end else begin
            state_nx_s = S_ACC1;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ACC1: begin
        if (mem_resp) begin
          state_nx_s = cap_cross_r ? S_ACC2 : S_DONE;
        end else begin
          state_nx_s = S_ACC1;
        end
      end
      S_ACC2: begin
        if (mem_resp) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_ACC2;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Load assembly: merge the returning lanes, align byte 'off' to bit 0, extend.
  always_comb begin
    rbuf_s = rbuf_r;
    if (state_r == S_ACC1 && mem_resp) begin
      rbuf_s[XLEN-1:0] = mem_rdata;
    end else begin
      rbuf_s[XLEN-1:0] = rbuf_r[XLEN-1:0];
    end
    if (state_r == S_ACC2 && mem_resp) begin
      rbuf_s[DW-1:XLEN] = mem_rdata;
    end else begin
      rbuf_s[DW-1:XLEN] = rbuf_r[DW-1:XLEN];
    end
    shifted_s  = rbuf_s >> {cap_off_r, 3'b000};
    nbits_s    = 7'd8 << cap_size_r;
    lowmask_s  = (XLEN'(1) << nbits_s) - XLEN'(1);
    msb_s      = lowmask_s & ~(lowmask_s >> 1);
    sgn_s      = !cap_unsigned_r && (|(shifted_s[XLEN-1:0] & msb_s));
    load_val_s = (shifted_s[XLEN-1:0] & lowmask_s) | (sgn_s ? ~lowmask_s : {XLEN{1'b0}});
  end

  // State, captured request and load buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      cap_store_r    <= 1'b0;
      cap_unsigned_r <= 1'b0;
      cap_cross_r    <= 1'b0;
      cap_size_r     <= 2'd0;
      cap_off_r      <= {OB{1'b0}};
      cap_base_r     <= {XLEN{1'b0}};
      cap_be_hi_r    <= {NB{1'b0}};
      cap_wd_hi_r    <= {XLEN{1'b0}};
      rbuf_r         <= {DW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      rbuf_r  <= rbuf_s;
      if (accept_s) begin
        cap_store_r    <= req_store;
        cap_unsigned_r <= req_funct3[2];
        cap_cross_r    <= req_cross_s;
        cap_size_r     <= req_funct3[1:0];
        cap_off_r      <= req_off_s;
        cap_base_r     <= {req_addr[XLEN-1:OB], {OB{1'b0}}};
        cap_be_hi_r    <= req_be_s[BW-1:NB];
        cap_wd_hi_r    <= req_wd_s[DW-1:XLEN];
      end
    end
  end

  // Registered outputs, loaded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_fault_r   <= 1'b0;
      rsp_rdata_r   <= {XLEN{1'b0}};
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_address_r <= {XLEN{1'b0}};
      mem_wdata_r   <= {XLEN{1'b0}};
      mem_be_r      <= {NB{1'b0}};
    end else begin
      req_ready_r <= state_nx_s inside {S_IDLE, S_DONE, S_FAULT};
      rsp_valid_r <= state_nx_s inside {S_DONE, S_FAULT};
      rsp_fault_r <= state_nx_s == S_FAULT;
      rsp_rdata_r <= (state_nx_s == S_DONE && !cap_store_r) ? load_val_s : {XLEN{1'b0}};
      if (accept_s && state_nx_s == S_ACC1) begin
        mem_read_r    <= !req_store;
        mem_write_r   <= req_store;
        mem_address_r <= {req_addr[XLEN-1:OB], {OB{1'b0}}};
        mem_be_r      <= req_be_s[NB-1:0];
        mem_wdata_r   <= req_wd_s[XLEN-1:0];
      end else if (state_r == S_ACC1 && state_nx_s == S_ACC2) begin
        // Second half of a split access: next word, upper halves of the lane masks.
        mem_address_r <= cap_base_r + XLEN'(NB);
        mem_be_r      <= cap_be_hi_r;
        mem_wdata_r   <= cap_wd_hi_r;
      end else if (state_nx_s == S_ACC1 || state_nx_s == S_ACC2) begin
        mem_read_r    <= mem_read_r;
        mem_write_r   <= mem_write_r;
        mem_address_r <= mem_address_r;
        mem_be_r      <= mem_be_r;
        mem_wdata_r   <= mem_wdata_r;
      end else begin
        mem_read_r    <= 1'b0;
        mem_write_r   <= 1'b0;
        mem_address_r <= {XLEN{1'b0}};
        mem_be_r      <= {NB{1'b0}};
        mem_wdata_r   <= {XLEN{1'b0}};
      end
    end
  end

  assign req_ready       = req_ready_r;
  assign rsp_valid       = rsp_valid_r;
  assign rsp_fault       = rsp_fault_r;
  assign rsp_rdata       = rsp_rdata_r;
  assign mem_read        = mem_read_r;
  assign mem_write       = mem_write_r;
  assign mem_address     = mem_address_r;
  assign mem_wdata       = mem_wdata_r;
  assign mem_byte_enable = mem_be_r;

endmodule

// File: tb/tb_lsu_datapath.sv
// Scoreboard bench for lsu_datapath: three configurations (32/split, 32/fault, 64/fault)
// sharing one stimulus driver, one memory responder and one response monitor.
module tb_lsu_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'h0, req_wdata = 64'h0, mem_rdata = 64'h0;
  logic        mem_resp_mon = 1'b0, stale_resp = 1'b0;
  logic        mem_resp_all;
  assign mem_resp_all = mem_resp_mon | stale_resp;

  logic        a_ready, a_vld, a_flt, a_rd, a_wr;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        b_ready, b_vld, b_flt, b_rd, b_wr;
  logic [31:0] b_rdata, b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        c_ready, c_vld, c_flt, c_rd, c_wr;
  logic [63:0] c_rdata, c_addr, c_wdata;
  logic [7:0]  c_be;

  lsu_datapath #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2'd0), .req_ready(a_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[31:0]), .rsp_valid(a_vld), .rsp_rdata(a_rdata), .rsp_fault(a_flt),
    .mem_read(a_rd), .mem_write(a_wr), .mem_address(a_addr), .mem_wdata(a_wdata),
    .mem_byte_enable(a_be), .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp_all && sel == 2'd0));

  lsu_datapath #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2'd1), .req_ready(b_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[31:0]), .rsp_valid(b_vld), .rsp_rdata(b_rdata), .rsp_fault(b_flt),
    .mem_read(b_rd), .mem_write(b_wr), .mem_address(b_addr), .mem_wdata(b_wdata),
    .mem_byte_enable(b_be), .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp_all && sel == 2'd1));

  lsu_datapath #(.XLEN(64), .ALLOW_MISALIGNED(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2'd2), .req_ready(c_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(c_vld), .rsp_rdata(c_rdata), .rsp_fault(c_flt),
    .mem_read(c_rd), .mem_write(c_wr), .mem_address(c_addr), .mem_wdata(c_wdata),
    .mem_byte_enable(c_be), .mem_rdata(mem_rdata), .mem_resp(mem_resp_all && sel == 2'd2));

  logic        o_ready, o_vld, o_flt, o_rd, o_wr;
  logic [63:0] o_rdata, o_addr, o_wdata;
  logic [7:0]  o_be;

  always_comb begin
    case (sel)
      2'd0: begin
        o_ready = a_ready; o_vld = a_vld; o_flt = a_flt; o_rd = a_rd; o_wr = a_wr;
        o_rdata = {32'h0, a_rdata}; o_addr = {32'h0, a_addr}; o_wdata = {32'h0, a_wdata};
        o_be = {4'h0, a_be};
      end
      2'd1: begin
        o_ready = b_ready; o_vld = b_vld; o_flt = b_flt; o_rd = b_rd; o_wr = b_wr;
        o_rdata = {32'h0, b_rdata}; o_addr = {32'h0, b_addr}; o_wdata = {32'h0, b_wdata};
        o_be = {4'h0, b_be};
      end
      default: begin
        o_ready = c_ready; o_vld = c_vld; o_flt = c_flt; o_rd = c_rd; o_wr = c_wr;
        o_rdata = c_rdata; o_addr = c_addr; o_wdata = c_wdata; o_be = c_be;
      end
    endcase
  end

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        wr;
    logic [63:0] rdata;
    int          waits;
  } acc_t;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
    int          acc_cyc;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   errors = 0, checks = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  // Memory responder: matches each access against the expected queue, then answers.
  acc_t cur;
  logic in_acc = 1'b0;
  int   wait_left = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_resp_mon = 1'b0;
      in_acc = 1'b0;
      acc_q.delete();
    end else begin
      if (mem_resp_mon) begin
        mem_resp_mon = 1'b0;
        in_acc = 1'b0;
      end
      chk("strobe_exclusive", {63'h0, o_rd & o_wr}, 64'h0);
      if ((o_rd || o_wr) && !in_acc) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_access: got addr %h be %h expected no access", o_addr, o_be);
          mem_resp_mon = 1'b1;
        end else begin
          cur = acc_q.pop_front();
          in_acc = 1'b1;
          wait_left = cur.waits;
        end
      end
      if (in_acc) begin
        chk("mem_address", o_addr, cur.addr);
        chk("mem_byte_enable", {56'h0, o_be}, {56'h0, cur.be});
        chk("mem_write", {63'h0, o_wr}, {63'h0, cur.wr});
        chk("mem_read", {63'h0, o_rd}, {63'h0, !cur.wr});
        if (cur.wr) chk("mem_wdata", o_wdata, cur.wdata);
        if (wait_left == 0) begin
          mem_resp_mon = 1'b1;
          mem_rdata = cur.rdata;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Response monitor: pops the expected response whenever rsp_valid is seen.
  rsp_t exp_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_q.delete();
    end else if (o_vld) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rdata %h fault %b expected no response", o_rdata, o_flt);
      end else begin
        exp_r = rsp_q.pop_front();
        chk("rsp_rdata", o_rdata, exp_r.rdata);
        chk("rsp_fault", {63'h0, o_flt}, {63'h0, exp_r.fault});
        chk("rsp_latency", 64'(cyc - exp_r.acc_cyc), 64'(exp_r.lat));
      end
    end
  end

  task automatic pa(input logic [63:0] addr, input logic [7:0] be, input logic [63:0] wd,
                    input logic wr, input logic [63:0] rd, input int waits);
    acc_t a;
    a.addr = addr; a.be = be; a.wdata = wd; a.wr = wr; a.rdata = rd; a.waits = waits;
    acc_q.push_back(a);
  endtask

  // Called at a negedge; returns at the following negedge with junk on the request bus.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input logic flt,
                       input int lat);
    rsp_t r;
    int n = 0;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
    end else begin
      r.rdata = exp_rd; r.fault = flt; r.lat = lat; r.acc_cyc = cyc;
      rsp_q.push_back(r);
    end
    @(negedge clk);
    req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111; req_addr = ~addr; req_wdata = ~wd;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0 || acc_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d rsp %0d acc pending expected 0", rsp_q.size(), acc_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, {63'h0, o_ready}, 64'h1);
    chk({tag, "_rsp_valid"}, {63'h0, o_vld}, 64'h0);
    chk({tag, "_rsp_fault"}, {63'h0, o_flt}, 64'h0);
    chk({tag, "_strobes"}, {62'h0, o_rd, o_wr}, 64'h0);
    chk({tag, "_be"}, {56'h0, o_be}, 64'h0);
    chk({tag, "_addr"}, o_addr, 64'h0);
    chk({tag, "_wdata"}, o_wdata, 64'h0);
    chk({tag, "_rdata"}, o_rdata, 64'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1 chk_idle("reset");
    end
    sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // XLEN=32, misaligned accesses split.
    pa(64'h1000, 8'h8, 64'h0, 1'b0, 64'h80FF_FF00, 0);
    issue(1'b0, 3'b000, 64'h1003, 64'h0, 64'hFFFF_FF80, 1'b0, 2);
    pa(64'h2000, 8'hC, 64'h0, 1'b0, 64'h9ABC_0000, 0);
    issue(1'b0, 3'b101, 64'h2002, 64'h0, 64'h0000_9ABC, 1'b0, 2);
    pa(64'h3000, 8'hE, 64'h2233_4400, 1'b1, 64'h0, 0);
    pa(64'h3004, 8'h1, 64'h0000_0011, 1'b1, 64'h0, 0);
    issue(1'b1, 3'b010, 64'h3001, 64'h1122_3344, 64'h0, 1'b0, 3);
    issue(1'b0, 3'b011, 64'h4000, 64'h0, 64'h0, 1'b1, 1);
    pa(64'h5000, 8'h8, 64'h0, 1'b0, 64'hAB00_0000, 1);
    pa(64'h5004, 8'h1, 64'h0, 1'b0, 64'h0000_00CD, 0);
    issue(1'b0, 3'b001, 64'h5003, 64'h0, 64'hFFFF_CDAB, 1'b0, 4);
    pa(64'h6000, 8'h4, 64'hBE5A_0000, 1'b1, 64'h0, 0);
    issue(1'b1, 3'b000, 64'h6002, 64'hDEAD_BE5A, 64'h0, 1'b0, 2);
    pa(64'h7000, 8'hF, 64'h0, 1'b0, 64'h1234_5678, 2);
    issue(1'b0, 3'b010, 64'h7000, 64'h0, 64'h1234_5678, 1'b0, 4);
    issue(1'b1, 3'b100, 64'h7100, 64'h55, 64'h0, 1'b1, 1);
    issue(1'b1, 3'b011, 64'h7200, 64'h55, 64'h0, 1'b1, 1);
    issue(1'b0, 3'b111, 64'h7300, 64'h0, 64'h0, 1'b1, 1);
    pa(64'h8000, 8'h2, 64'h0, 1'b0, 64'h0000_F100, 0);
    issue(1'b0, 3'b100, 64'h8001, 64'h0, 64'h0000_00F1, 1'b0, 2);
    pa(64'hFFFF_FFFC, 8'h8, 64'hB200_0000, 1'b1, 64'h0, 0);
    pa(64'h0000_0000, 8'h1, 64'h0000_00A1, 1'b1, 64'h0, 0);
    issue(1'b1, 3'b001, 64'hFFFF_FFFF, 64'h0000_A1B2, 64'h0, 1'b0, 3);
    drain();

    // XLEN=32, misalignment faults.
    sel = 2'd1;
    @(negedge clk);
    issue(1'b0, 3'b010, 64'h3002, 64'h0, 64'h0, 1'b1, 1);
    pa(64'h3000, 8'h6, 64'h0, 1'b0, 64'h00AB_CD00, 0);
    issue(1'b0, 3'b001, 64'h3001, 64'h0, 64'hFFFF_ABCD, 1'b0, 2);
    pa(64'h3000, 8'h8, 64'h5A00_0000, 1'b1, 64'h0, 0);
    issue(1'b1, 3'b000, 64'h3003, 64'h5A, 64'h0, 1'b0, 2);
    issue(1'b1, 3'b001, 64'h3003, 64'h5A5A, 64'h0, 1'b1, 1);
    drain();

    // XLEN=64, misalignment faults.
    sel = 2'd2;
    @(negedge clk);
    pa(64'h10, 8'hFF, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 3);
    issue(1'b0, 3'b011, 64'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 5);
    pa(64'h20, 8'hF0, 64'h0, 1'b0, 64'h89AB_CDEF_0000_0000, 0);
    issue(1'b0, 3'b110, 64'h24, 64'h0, 64'h0000_0000_89AB_CDEF, 1'b0, 2);
    pa(64'h20, 8'hF0, 64'h0, 1'b0, 64'h89AB_CDEF_0000_0000, 0);
    issue(1'b0, 3'b010, 64'h24, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 2);
    pa(64'h18, 8'hFF, 64'h1122_3344_5566_7788, 1'b1, 64'h0, 0);
    issue(1'b1, 3'b011, 64'h18, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 2);
    issue(1'b0, 3'b010, 64'h3006, 64'h0, 64'h0, 1'b1, 1);
    issue(1'b0, 3'b111, 64'h40, 64'h0, 64'h0, 1'b1, 1);
    drain();

    // Reset in the middle of an access, then a stale mem_resp.
    sel = 2'd0;
    @(negedge clk);
    pa(64'h9000, 8'hF, 64'h0, 1'b0, 64'h0, 1000);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 64'h9000;
    @(negedge clk);
    req_valid = 1'b0;
    begin
      int n = 0;
      while (!o_rd && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("abort_mem_read_before", {63'h0, o_rd}, 64'h1);
    #2 rst_n = 1'b0;
    #1 chk("abort_mem_read_async", {63'h0, o_rd}, 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    stale_resp = 1'b1;
    @(negedge clk);
    stale_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {63'h0, o_vld}, 64'h0);
      chk("abort_req_ready", {63'h0, o_ready}, 64'h1);
      chk("abort_no_strobe", {62'h0, o_rd, o_wr}, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
